// File: rtl/bottling_run_controller_if.sv
// Signal bundle between the run controller and the setting / display / sensor logic.
// Valid/ready note: there is no backpressure; in_start, in_abort and in_pill are one-cycle event strobes
// that are acted on at the rising edge where they are high. in_pause is a level.
interface bottling_run_controller_if;
  logic        in_start;
  logic        in_abort;
  logic        in_pause;
  logic        in_pill;
  logic [5:0]  in_target_bottle_num;
  logic [5:0]  in_target_pill_num;
  logic [1:0]  out_state;
  logic        out_paused;
  logic        out_valve_open;
  logic        out_bottle_advance;
  logic [5:0]  out_cur_bottle_num;
  logic [5:0]  out_cur_pill_num;
  logic [11:0] out_total_pill_num;
  logic        out_error;
  logic [2:0]  dbg_state;

  modport master (
    output in_start, in_abort, in_pause, in_pill, in_target_bottle_num, in_target_pill_num,
    input  out_state, out_paused, out_valve_open, out_bottle_advance,
           out_cur_bottle_num, out_cur_pill_num, out_total_pill_num, out_error, dbg_state
  );

  modport slave (
    input  in_start, in_abort, in_pause, in_pill, in_target_bottle_num, in_target_pill_num,
    output out_state, out_paused, out_valve_open, out_bottle_advance,
           out_cur_bottle_num, out_cur_pill_num, out_total_pill_num, out_error, dbg_state
  );
endinterface

// File: rtl/bottling_run_controller.sv
// Sequences one bottling run: latches targets, gates the pill valve, counts pills,
// pulses the conveyor between bottles and parks in REPORT when the last bottle is full.
module bottling_run_controller #(
  parameter int CHANGE_CYCLES = 4
) (
  input logic                        in_PULSE,
  input logic                        in_CLR,
  bottling_run_controller_if.slave   bus
);

  localparam int CW = (CHANGE_CYCLES > 1) ? $clog2(CHANGE_CYCLES) : 1;
  localparam logic [CW-1:0] CHG_LAST = CW'(CHANGE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_PAUSED = 3'd2,
    S_CHANGE = 3'd3,
    S_REPORT = 3'd4
  } state_t;

  state_t        state;
  logic [5:0]    tgt_bottle;
  logic [5:0]    tgt_pill;
  logic [5:0]    cur_bottle;
  logic [5:0]    cur_pill;
  logic [11:0]   total_pill;
  logic          error_flag;
  logic [CW-1:0] chg_cnt;

  logic [5:0]    pill_next;
  logic          targets_ok;

  assign pill_next  = cur_pill + 6'd1;
  assign targets_ok = (bus.in_target_bottle_num != 6'd0) && (bus.in_target_pill_num != 6'd0);

  // Abort outranks start, which outranks pill counting, which outranks pause.
  always_ff @(posedge in_PULSE or negedge in_CLR) begin
    if (!in_CLR) begin
      state      <= S_IDLE;
      tgt_bottle <= 6'd0;
      tgt_pill   <= 6'd0;
      cur_bottle <= 6'd0;
      cur_pill   <= 6'd0;
      total_pill <= 12'd0;
      error_flag <= 1'b0;
      chg_cnt    <= '0;
    end else if (bus.in_abort) begin
      if (state != S_IDLE) begin
        state   <= S_IDLE;
        chg_cnt <= '0;
      end
    end else begin
      case (state)
        S_IDLE, S_REPORT: begin
          if (bus.in_start) begin
            if (targets_ok) begin
              tgt_bottle <= bus.in_target_bottle_num;
              tgt_pill   <= bus.in_target_pill_num;
              cur_bottle <= 6'd0;
              cur_pill   <= 6'd0;
              total_pill <= 12'd0;
              error_flag <= 1'b0;
              chg_cnt    <= '0;
              state      <= S_FILL;
            end else begin
              error_flag <= 1'b1;
            end
          end
        end

        S_FILL: begin
          if (bus.in_pill) begin
            cur_pill   <= pill_next;
            total_pill <= total_pill + 12'd1;
            if (pill_next == tgt_pill) begin
              cur_bottle <= cur_bottle + 6'd1;
              chg_cnt    <= '0;
              state      <= S_CHANGE;
            end else if (bus.in_pause) begin
              state <= S_PAUSED;
            end
          end else if (bus.in_pause) begin
            state <= S_PAUSED;
          end
        end

        S_PAUSED: begin
          if (!bus.in_pause) begin
            state <= S_FILL;
          end
        end

        S_CHANGE: begin
          if (chg_cnt == CHG_LAST) begin
            chg_cnt <= '0;
            // The finished run keeps the full per-bottle count on display.
            if (cur_bottle == tgt_bottle) begin
              state <= S_REPORT;
            end else begin
              cur_pill <= 6'd0;
              state    <= S_FILL;
            end
          end else begin
            chg_cnt <= chg_cnt + 1'b1;
          end
        end

        default: begin
          state   <= S_IDLE;
          chg_cnt <= '0;
        end
      endcase
    end
  end

  // Decoded from the state register only, so reset clears them without a clock edge.
  always_comb begin
    bus.out_state = 2'b01;
    case (state)
      S_IDLE:   bus.out_state = 2'b00;
      S_REPORT: bus.out_state = 2'b11;
      default:  bus.out_state = 2'b01;
    endcase
  end

  assign bus.out_paused         = (state == S_PAUSED);
  assign bus.out_valve_open     = (state == S_FILL);
  assign bus.out_bottle_advance = (state == S_CHANGE);
  assign bus.out_cur_bottle_num = cur_bottle;
  assign bus.out_cur_pill_num   = cur_pill;
  assign bus.out_total_pill_num = total_pill;
  assign bus.out_error          = error_flag;
  assign bus.dbg_state          = state;

endmodule
